perf_counter_unit: RTL and testbench
====================================

Name: perf_counter_unit

Overview:
- Synthesizable pipeline performance-monitoring unit for the riscv_top core; consumes the core's per-cycle stat strobes: branch/jump type, PL flush, IF/EX stall and ecall.
- Accumulates cycle, retired-instruction, stall and per-channel branch-prediction counters in hardware.
- Supports a configurable channel count, counter width and wrap/saturate mode, a sticky halt freeze, synchronous clear and a registered read port for debug/CSR access.

Parameters:
- NUM_BR, 8: number of branch/jump event channels (1..125).
- CNT_W, 32: width of every counter (8..64).
- FLUSH_PENALTY, 2: instructions removed from the retired count on a flush cycle.
- SATURATE, 0: 0 = counters wrap modulo 2^CNT_W; 1 = counters hold at all-ones.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ev_br  in  NUM_BR  one-hot-or-zero branch/jump resolve strobes, bit i = channel i.
- ev_flush  in  1  pipeline flush (misprediction) this cycle.
- ev_stall_if  in  1  IF stall this cycle.
- ev_stall_ex  in  1  EX stall this cycle.
- ev_halt  in  1  ecall/halt strobe.
- clr  in  1  synchronous clear of all counters and flags.
- rd_en  in  1  read request.
- rd_addr  in  8  counter index.
- rd_data  out  CNT_W  registered read data.
- rd_valid  out  1  rd_data valid, one cycle after rd_en.
- halted  out  1  sticky halt flag.
- ovf  out  1  sticky overflow flag: any counter wrapped or saturated.

Behaviour:
- Reset (rst_n low, async): all counters 0, halted=0, ovf=0, rd_data=0, rd_valid=0.
- Active cycle: a cycle with rst_n high, clr=0, halted=0 and ev_halt=0.
  - Counting happens only in active cycles.
  - The ev_halt cycle itself is not counted.
  - halted sets at the next edge and stays set until clr or reset.
- Counter updates per active cycle:
  - cycles: +1 every active cycle.
  - stall_if: +1 if ev_stall_if. stall_ex: +1 if ev_stall_ex.
  - instr: +0 if either stall; else -FLUSH_PENALTY if ev_flush, clamped at 0 (never underflows, ovf not set); else +1.
  - br_sum_total: +1 if any ev_br bit set. br_sum_failed: +1 if any ev_br bit set and ev_flush.
  - br_total[i]: +1 if ev_br[i]. br_failed[i]: +1 if ev_br[i] and ev_flush.
  - A multi-hot ev_br counts each set channel once; the sum counters still increment by only 1.
- Width rules: all increments are CNT_W-bit unsigned.
  - At all-ones, an increment wraps to 0 (SATURATE=0) or holds (SATURATE=1).
  - Either case sets ovf.
- clr: at the next edge zeroes all counters, halted and ovf.
  - clr has priority over every event in the same cycle.
  - clr together with ev_halt leaves halted=0.
- Read port: on rd_en, rd_data at the next edge = value of counter rd_addr before that edge's update; rd_valid=1 for exactly that cycle.
  - rd_en=0: rd_valid=0 next cycle and rd_data holds its last value.
  - Reads are allowed while halted and in the clr cycle; the clr-cycle read returns the pre-clear value.
- Address map:
  - 0 cycles, 1 instr, 2 stall_if, 3 stall_ex, 4 br_sum_total, 5 br_sum_failed.
  - 6+2i br_total[i], 7+2i br_failed[i].
  - Addresses >= 6+2*NUM_BR read as 0 with rd_valid=1.
- Reset mid-operation: async clear regardless of clr/halted state; a read in flight is discarded (rd_valid=0).

Test Plan:
- Release reset, 10 active cycles with no events, read addr 0 and 1 -> 10 and 10, rd_valid high exactly 1 cycle after each rd_en.
- 4 cycles ev_stall_if, 3 cycles ev_stall_ex, 5 plain cycles, 1 flush cycle (FLUSH_PENALTY=2) -> instr=3, stall_if=4, stall_ex=3, cycles=13. A flush on instr=1 -> instr=0.
- ev_br=bit1 for 6 cycles with flush on 2 of them, ev_br=bit5 for 3 cycles -> addr 8=6, 9=2, 16=3, 17=0, 4=9, 5=2. ev_br=0x22 for one cycle -> addr 4 +1, addr 8 +1, addr 16 +1. Read addr 200 -> 0.
- ev_halt after 20 cycles, then 10 more cycles of events -> cycles=20, halted=1, counters frozen and readable. clr -> all 0, halted=0, counting resumes.
- CNT_W=8, 260 active cycles, SATURATE=0 -> cycles=4, ovf=1. Same with SATURATE=1 -> cycles=255, ovf=1.
- clr with rd_en on addr 0 (value 7) and ev_br asserted -> rd_data=7, then reads show all counters 0. rst_n pulsed low mid-count -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/perf_counter_unit.sv
`default_nettype none
// ============================================================================
// perf_counter_unit : pipeline performance counters with sticky halt freeze,
//                     wrap/saturate overflow flag and a registered read port.
// Revision 1.0
// ============================================================================
module perf_counter_unit #(
  parameter int NUM_BR        = 8,
  parameter int CNT_W         = 32,
  parameter int FLUSH_PENALTY = 2,
  parameter int SATURATE      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_BR-1:0] ev_br,
  input  logic              ev_flush,
  input  logic              ev_stall_if,
  input  logic              ev_stall_ex,
  input  logic              ev_halt,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [7:0]        rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              halted,
  output logic              ovf
);

  localparam int               c_NUM_CNT = 6 + 2 * NUM_BR;
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_PENALTY = CNT_W'(FLUSH_PENALTY);

  logic [CNT_W-1:0]     r_cnt    [c_NUM_CNT];
  logic [CNT_W-1:0]     w_next   [c_NUM_CNT];
  logic                 w_at_max [c_NUM_CNT];
  logic [c_NUM_CNT-1:0] w_inc;
  logic [CNT_W-1:0]     w_rd_mux;
  logic                 w_any_max;
  logic                 w_active;
  logic                 r_halted;
  logic                 r_ovf;
  logic [CNT_W-1:0]     r_rd_data;
  logic                 r_rd_valid;

  assign w_active = !clr && !r_halted && !ev_halt;

  // Bit 1 (instr) means "not stalled"; the flush decrement is resolved in g_instr.
  always_comb begin
    w_inc    = '0;
    w_inc[0] = 1'b1;
    w_inc[1] = !(ev_stall_if || ev_stall_ex);
    w_inc[2] = ev_stall_if;
    w_inc[3] = ev_stall_ex;
    w_inc[4] = |ev_br;
    w_inc[5] = (|ev_br) && ev_flush;
    for (int i = 0; i < NUM_BR; i++) begin
      w_inc[6 + 2 * i] = ev_br[i];
      w_inc[7 + 2 * i] = ev_br[i] && ev_flush;
    end
  end

  for (genvar k = 0; k < c_NUM_CNT; k++) begin : g_cnt
    if (k == 1) begin : g_instr
      always_comb begin
        w_next[k]   = r_cnt[k];
        w_at_max[k] = 1'b0;
        if (w_inc[k]) begin
          if (ev_flush) begin
            w_next[k] = (r_cnt[k] >= c_PENALTY) ? (r_cnt[k] - c_PENALTY) : '0;
          end else if (&r_cnt[k]) begin
            w_at_max[k] = 1'b1;
            w_next[k]   = (SATURATE != 0) ? r_cnt[k] : '0;
          end else begin
            w_next[k] = r_cnt[k] + c_ONE;
          end
        end
      end
    end else begin : g_event
      always_comb begin
        w_next[k]   = r_cnt[k];
        w_at_max[k] = 1'b0;
        if (w_inc[k]) begin
          if (&r_cnt[k]) begin
            w_at_max[k] = 1'b1;
            w_next[k]   = (SATURATE != 0) ? r_cnt[k] : '0;
          end else begin
            w_next[k] = r_cnt[k] + c_ONE;
          end
        end
      end
    end
  end

  always_comb begin
    w_any_max = 1'b0;
    w_rd_mux  = '0;
    for (int k = 0; k < c_NUM_CNT; k++) begin
      w_any_max = w_any_max | w_at_max[k];
      if (rd_addr == 8'(k)) begin
        w_rd_mux = r_cnt[k];
      end
    end
  end

  // Read port samples the pre-update values, so a read in the clr cycle sees old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_NUM_CNT; k++) begin
        r_cnt[k] <= '0;
      end
      r_halted   <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_mux;
      end
      if (clr) begin
        for (int k = 0; k < c_NUM_CNT; k++) begin
          r_cnt[k] <= '0;
        end
        r_halted <= 1'b0;
        r_ovf    <= 1'b0;
      end else begin
        if (ev_halt) begin
          r_halted <= 1'b1;
        end
        if (w_active) begin
          for (int k = 0; k < c_NUM_CNT; k++) begin
            r_cnt[k] <= w_next[k];
          end
          if (w_any_max) begin
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign halted   = r_halted;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_unit.sv
`default_nettype none
// ============================================================================
// tb_perf_counter_unit : directed, table-driven bench for perf_counter_unit.
// Revision 1.0
// ============================================================================
module tb_perf_counter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  ev_br = '0;
  logic        ev_flush = 1'b0;
  logic        ev_stall_if = 1'b0;
  logic        ev_stall_ex = 1'b0;
  logic        ev_halt = 1'b0;
  logic        clr = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid, halted, ovf;
  logic [7:0]  rd_data_w, rd_data_s;
  logic        rd_valid_w, rd_valid_s, halted_w, halted_s, ovf_w, ovf_s;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  perf_counter_unit dut (
    .clk(clk), .rst_n(rst_n), .ev_br(ev_br), .ev_flush(ev_flush),
    .ev_stall_if(ev_stall_if), .ev_stall_ex(ev_stall_ex), .ev_halt(ev_halt),
    .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .halted(halted), .ovf(ovf)
  );

  perf_counter_unit #(.CNT_W(8), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .ev_br(ev_br), .ev_flush(ev_flush),
    .ev_stall_if(ev_stall_if), .ev_stall_ex(ev_stall_ex), .ev_halt(ev_halt),
    .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w),
    .rd_valid(rd_valid_w), .halted(halted_w), .ovf(ovf_w)
  );

  perf_counter_unit #(.CNT_W(8), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .ev_br(ev_br), .ev_flush(ev_flush),
    .ev_stall_if(ev_stall_if), .ev_stall_ex(ev_stall_ex), .ev_halt(ev_halt),
    .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s),
    .rd_valid(rd_valid_s), .halted(halted_s), .ovf(ovf_s)
  );

  typedef struct {
    logic       clr;
    logic       halt;
    logic       flush;
    logic [7:0] br;
    logic       rd;
    logic [7:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [63:0] exp, input string nm);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({nm, ".valid"}, 64'(rd_valid), 64'd1);
    chk(nm, 64'(rd_data), exp);
  endtask

  task automatic idle(input int n);
    ev_br = '0; ev_flush = 0; ev_stall_if = 0; ev_stall_ex = 0; ev_halt = 0; clr = 0;
    repeat (n) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    // Branch table: clr, halt, flush, br, rd, addr, expected read data.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0,   32'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 8'd0,   32'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 8'd0,   32'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 8'd0,   32'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 8'd0,   32'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 8'd0,   32'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 8'd0,   32'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 8'd0,   32'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 8'd0,   32'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 8'd0,   32'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'd8,   32'd6};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd9,   32'd2};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd16,  32'd3};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd17,  32'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd4,   32'd9};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd5,   32'd2};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd200, 32'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0,   32'd9};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd22,  32'd0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0,   32'd0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 8'd0,   32'd0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'd4,   32'd1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd8,   32'd1};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd16,  32'd1};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd5,   32'd0};
    tbl[25] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd9,   32'd0};

    // Reset state
    #3 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst.rd_data", 64'(rd_data), 64'd0);
    chk("rst.rd_valid", 64'(rd_valid), 64'd0);
    chk("rst.halted", 64'(halted), 64'd0);
    chk("rst.ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;

    // 10 idle cycles, then freeze with halt and read cycles/instr
    idle(10);
    ev_halt = 1'b1;
    rd(8'd0, 64'd10, "idle.cycles");
    ev_halt = 1'b0;
    chk("idle.halted", 64'(halted), 64'd1);
    rd(8'd1, 64'd10, "idle.instr");
    tick();
    chk("idle.valid_drop", 64'(rd_valid), 64'd0);
    chk("idle.data_hold", 64'(rd_data), 64'd10);

    // Stalls and flush penalty
    do_clr();
    chk("clr.halted", 64'(halted), 64'd0);
    ev_stall_if = 1'b1; repeat (4) tick(); ev_stall_if = 1'b0;
    ev_stall_ex = 1'b1; repeat (3) tick(); ev_stall_ex = 1'b0;
    idle(5);
    ev_flush = 1'b1; tick(); ev_flush = 1'b0;
    ev_halt = 1'b1;
    rd(8'd0, 64'd13, "stall.cycles");
    ev_halt = 1'b0;
    rd(8'd1, 64'd3, "stall.instr");
    rd(8'd2, 64'd4, "stall.if");
    rd(8'd3, 64'd3, "stall.ex");
    rd(8'd5, 64'd0, "stall.br_failed");

    // Flush on instr=1 clamps to 0 without flagging overflow
    do_clr();
    idle(1);
    ev_flush = 1'b1; tick(); ev_flush = 1'b0;
    ev_halt = 1'b1;
    rd(8'd1, 64'd0, "clamp.instr");
    ev_halt = 1'b0;
    rd(8'd0, 64'd2, "clamp.cycles");
    chk("clamp.ovf", 64'(ovf), 64'd0);

    // Branch channels, multi-hot, out-of-range addresses
    foreach (tbl[i]) begin
      clr      = tbl[i].clr;
      ev_halt  = tbl[i].halt;
      ev_flush = tbl[i].flush;
      ev_br    = tbl[i].br;
      rd_en    = tbl[i].rd;
      rd_addr  = tbl[i].addr;
      tick();
      chk($sformatf("vec%0d.valid", i), 64'(rd_valid), 64'(tbl[i].rd));
      if (tbl[i].rd) begin
        chk($sformatf("vec%0d.data", i), 64'(rd_data), 64'(tbl[i].exp));
      end
    end
    rd_en = 1'b0;
    idle(0);

    // Halt freezes counters; clr with ev_halt leaves halted clear
    do_clr();
    ev_stall_if = 1'b1; repeat (20) tick(); ev_stall_if = 1'b0;
    ev_halt = 1'b1; tick(); ev_halt = 1'b0;
    chk("halt.halted", 64'(halted), 64'd1);
    ev_br = 8'h01; ev_flush = 1'b1; ev_stall_ex = 1'b1;
    repeat (10) tick();
    idle(0);
    chk("halt.still", 64'(halted), 64'd1);
    rd(8'd0, 64'd20, "halt.cycles");
    rd(8'd2, 64'd20, "halt.stall_if");
    rd(8'd3, 64'd0, "halt.stall_ex");
    rd(8'd6, 64'd0, "halt.br0");
    clr = 1'b1; ev_halt = 1'b1; tick(); clr = 1'b0; ev_halt = 1'b0;
    chk("clrhalt.halted", 64'(halted), 64'd0);
    rd(8'd0, 64'd0, "resume.cycles0");
    idle(3);
    rd(8'd0, 64'd4, "resume.cycles4");

    // 8-bit wrap and saturate
    do_clr();
    idle(255);
    chk("w255.ovf_wrap", 64'(ovf_w), 64'd0);
    chk("w255.ovf_sat", 64'(ovf_s), 64'd0);
    idle(1);
    chk("w256.ovf_wrap", 64'(ovf_w), 64'd1);
    chk("w256.ovf_sat", 64'(ovf_s), 64'd1);
    idle(4);
    ev_halt = 1'b1;
    rd(8'd0, 64'd260, "w260.cycles32");
    ev_halt = 1'b0;
    chk("w260.wrap", 64'(rd_data_w), 64'd4);
    chk("w260.sat", 64'(rd_data_s), 64'd255);
    chk("w260.ovf32", 64'(ovf), 64'd0);

    // Read in the clr cycle returns the pre-clear value
    do_clr();
    idle(7);
    clr = 1'b1; ev_br = 8'h01;
    rd(8'd0, 64'd7, "clrrd.cycles");
    clr = 1'b0; ev_br = '0;
    chk("clrrd.ovf_wrap", 64'(ovf_w), 64'd0);
    ev_halt = 1'b1;
    rd(8'd0, 64'd0, "clrrd.cycles0");
    ev_halt = 1'b0;
    rd(8'd4, 64'd0, "clrrd.br_sum");
    rd(8'd6, 64'd0, "clrrd.br0");

    // Asynchronous reset mid-operation discards the in-flight read
    do_clr();
    idle(5);
    ev_halt = 1'b1;
    rd(8'd0, 64'd5, "pre_rst.cycles");
    ev_halt = 1'b0;
    rd_en = 1'b1; rd_addr = 8'd1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.rd_data", 64'(rd_data), 64'd0);
    chk("arst.rd_valid", 64'(rd_valid), 64'd0);
    chk("arst.halted", 64'(halted), 64'd0);
    tick();
    chk("arst.held_valid", 64'(rd_valid), 64'd0);
    rd_en = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
